// File: rtl/pitch_event_encoder.sv
// pitch_event_encoder: turns four raw umpire buttons into strike/ball counter
// updates plus strikeout and walk events.
// Each button is synchronized, then debounced, and its rising edge sets a
// pending flag. A small IDLE -> ISSUE -> SETTLE sequencer services one flag
// per pass, in the priority order STRIKE > FOUL > BALL > HIT.
// Optional feature macro: FOUL_BUTTON_EN. When it is undefined, iBTN_FOUL is
// left unconnected to any logic.
// Handshake: there is no back-pressure. Every output is a registered one-cycle
// pulse, and the receiving counters must take it in the cycle it is high.
// Output pulses appear one cycle after the ISSUE state, so they lag the state
// register by one cycle.

// Per-button front end: two-flop synchronizer, saturating debounce counter,
// debounced level and rising-edge detect.
module pitch_event_encoder_deb #(
  parameter int unsigned DEB_LEN = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic rise_o
);
  localparam logic [15:0] DebMax = DEB_LEN[15:0];

  logic        sync1_q, sync2_q;
  logic [15:0] cnt_q, cnt_d;
  logic        lvl_q, lvl_d, lvl_dly_q;

  // Counter counts consecutive high samples, saturating; any low sample clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (!sync2_q)              cnt_d = '0;
    else if (cnt_q < DebMax)   cnt_d = cnt_q + 16'd1;
    lvl_d = sync2_q && (cnt_d == DebMax);
  end

  // Synchronizer, debounce state and edge-detect registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cnt_q     <= '0;
      lvl_q     <= 1'b0;
      lvl_dly_q <= 1'b0;
    end else begin
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      lvl_q     <= lvl_d;
      lvl_dly_q <= lvl_q;
    end
  end

  assign rise_o = lvl_q & ~lvl_dly_q;
endmodule

module pitch_event_encoder #(
  parameter int unsigned DEB_LEN = 50000
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iBTN_STRIKE,
  input  logic       iBTN_BALL,
  input  logic       iBTN_FOUL,
  input  logic       iBTN_HIT,
  input  logic [1:0] iSTRIKE_CNT,
  input  logic [2:0] iBALL_CNT,
  output logic       oSTRIKE,
  output logic       oBALL,
  output logic       oCNT_CLRn,
  output logic       oOUT,
  output logic       oWALK
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SETTLE} state_e;

  // Flag index order is also the service priority: 0 is serviced first.
  localparam logic [1:0] SrcStrike = 2'd0;
  localparam logic [1:0] SrcFoul   = 2'd1;
  localparam logic [1:0] SrcBall   = 2'd2;
  localparam logic [1:0] SrcHit    = 2'd3;

  logic [3:0] rise;
  logic [3:0] pend_q, pend_d, take;
  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic       strike_q, strike_d, ball_q, ball_d, out_q, out_d, walk_q, walk_d;
  logic       clrn_q, clrn_d;

  // Only the MSB of each thermometer code matters; the lower bits are unused.
  logic [2:0] unused_cnt_bits;
  assign unused_cnt_bits = {iSTRIKE_CNT[0], iBALL_CNT[1:0]};

  pitch_event_encoder_deb #(.DEB_LEN(DEB_LEN)) u_deb_strike (
    .clk_i(iCLK), .rst_i(iRST), .btn_i(iBTN_STRIKE), .rise_o(rise[SrcStrike]));
  pitch_event_encoder_deb #(.DEB_LEN(DEB_LEN)) u_deb_ball (
    .clk_i(iCLK), .rst_i(iRST), .btn_i(iBTN_BALL), .rise_o(rise[SrcBall]));
  pitch_event_encoder_deb #(.DEB_LEN(DEB_LEN)) u_deb_hit (
    .clk_i(iCLK), .rst_i(iRST), .btn_i(iBTN_HIT), .rise_o(rise[SrcHit]));
`ifdef FOUL_BUTTON_EN
  pitch_event_encoder_deb #(.DEB_LEN(DEB_LEN)) u_deb_foul (
    .clk_i(iCLK), .rst_i(iRST), .btn_i(iBTN_FOUL), .rise_o(rise[SrcFoul]));
`else
  logic unused_foul;
  assign unused_foul    = iBTN_FOUL;
  assign rise[SrcFoul]  = 1'b0;
`endif

  // Sequencer next state, flag service and the single ISSUE-cycle action.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    take     = '0;
    strike_d = 1'b0;
    ball_d   = 1'b0;
    out_d    = 1'b0;
    walk_d   = 1'b0;
    clrn_d   = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (|pend_q) begin
          state_d = S_ISSUE;
          if (pend_q[SrcStrike])    sel_d = SrcStrike;
          else if (pend_q[SrcFoul]) sel_d = SrcFoul;
          else if (pend_q[SrcBall]) sel_d = SrcBall;
          else                      sel_d = SrcHit;
          take = 4'b0001 << sel_d;
        end
      end
      S_ISSUE: begin
        state_d = S_SETTLE;
        case (sel_q)
          SrcStrike: begin
            if (iSTRIKE_CNT[1]) begin out_d = 1'b1; clrn_d = 1'b0; end
            else                      strike_d = 1'b1;
          end
          SrcFoul: begin
            if (!iSTRIKE_CNT[1]) strike_d = 1'b1;
          end
          SrcBall: begin
            if (iBALL_CNT[2]) begin walk_d = 1'b1; clrn_d = 1'b0; end
            else                    ball_d = 1'b1;
          end
          default: clrn_d = 1'b0;
        endcase
      end
      S_SETTLE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // A new edge wins over the clear, so no press is lost.
    pend_d = (pend_q & ~take) | rise;
  end

  // Sequencer state, pending flags and registered output pulses.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q  <= S_IDLE;
      sel_q    <= SrcStrike;
      pend_q   <= '0;
      strike_q <= 1'b0;
      ball_q   <= 1'b0;
      out_q    <= 1'b0;
      walk_q   <= 1'b0;
      clrn_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      pend_q   <= pend_d;
      strike_q <= strike_d;
      ball_q   <= ball_d;
      out_q    <= out_d;
      walk_q   <= walk_d;
      clrn_q   <= clrn_d;
    end
  end

  assign oSTRIKE   = strike_q;
  assign oBALL     = ball_q;
  assign oOUT      = out_q;
  assign oWALK     = walk_q;
  assign oCNT_CLRn = clrn_q;
endmodule
